sim_phase_sequencer: RTL

- Frame-level controller directly upstream of the node array.
- Generates the verlet_state and fix_constraint_state phase strobes that every node consumes.
- Latches the mouse coordinates once per frame so all nodes see stable x_mouse/y_mouse for the whole frame.
- Raises finish_sig when a frame's integration and constraint relaxation are complete, then holds off until the renderer releases.

---
 rtl/sim_pkg.sv | 23 ++
 rtl/phase_timer.sv | 27 ++
 rtl/sim_phase_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sim_pkg.sv
// Shared simulation types: sequencer state encoding and default widths,
// also used by the node array for its coordinate width.
package sim_pkg;

  localparam int unsigned SIM_COORD_W          = 32;
  localparam int unsigned SIM_CONSTRAINT_ITERS = 8;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_VERLET      = 3'd1,
    ST_FIX         = 3'd2,
    ST_DONE        = 3'd3,
    ST_WAIT_RENDER = 3'd4
  } sim_state_e;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned sim_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with terminal-count flag; times each phase of a frame.
module phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/sim_phase_sequencer.sv
// Frame-level phase sequencer feeding the node array (verlet / constraint strobes).
// Optional macro SIM_FRAME_QUEUE_EN: one-deep queue for frame requests made while busy.
module sim_phase_sequencer
  import sim_pkg::*;
#(
  parameter  int unsigned CONSTRAINT_ITERS = SIM_CONSTRAINT_ITERS,
  parameter  int unsigned FIX_CYCLES       = 1,
  parameter  int unsigned VERLET_CYCLES    = 1,
  parameter  int unsigned COORD_W          = SIM_COORD_W,
  localparam int unsigned IDX_W            = sim_width(CONSTRAINT_ITERS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               render_busy,
  input  logic [COORD_W-1:0] x_mouse_in,
  input  logic [COORD_W-1:0] y_mouse_in,
  output logic               verlet_state,
  output logic               fix_constraint_state,
  output logic [COORD_W-1:0] x_mouse,
  output logic [COORD_W-1:0] y_mouse,
  output logic [IDX_W-1:0]   iter_idx,
  output logic               busy,
  output logic               finish_sig
);

  localparam int unsigned MAX_LOAD = ((VERLET_CYCLES > FIX_CYCLES) ? VERLET_CYCLES : FIX_CYCLES) - 1;
  localparam int unsigned CNT_W    = sim_width(MAX_LOAD);
  localparam logic [CNT_W-1:0] VERLET_LOAD = CNT_W'(VERLET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIX_LOAD    = CNT_W'(FIX_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_ITER   = IDX_W'((CONSTRAINT_ITERS == 0) ? 0 : CONSTRAINT_ITERS - 1);

  sim_state_e       r_state;
  sim_state_e       w_next_state;
  logic             w_launch;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tc;
  logic             w_timer_en;
  logic [IDX_W-1:0] w_next_iter;

  logic               r_verlet;
  logic               r_fix;
  logic               r_finish;
  logic               r_busy;
  logic [IDX_W-1:0]   r_iter_idx;
  logic [COORD_W-1:0] r_x_mouse;
  logic [COORD_W-1:0] r_y_mouse;

`ifdef SIM_FRAME_QUEUE_EN
  logic r_pending;

  // Pending drains on any IDLE cycle, which is exactly the cycle it launches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_pending <= 1'b0;
    end else if (frame_start) begin
      r_pending <= 1'b1;
    end
  end

  assign w_launch = frame_start | r_pending;
`else
  assign w_launch = frame_start;
`endif

  assign w_timer_en = (r_state == ST_VERLET) || (r_state == ST_FIX);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_timer_en),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = VERLET_LOAD;
    w_next_iter  = r_iter_idx;
    unique case (r_state)
      ST_IDLE: begin
        w_next_iter = '0;
        if (w_launch) begin
          w_next_state = ST_VERLET;
          w_load       = 1'b1;
        end
      end
      ST_VERLET: begin
        if (w_tc) begin
          if (CONSTRAINT_ITERS == 0) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_FIX;
            w_load       = 1'b1;
            w_load_val   = FIX_LOAD;
            w_next_iter  = '0;
          end
        end
      end
      ST_FIX: begin
        if (w_tc) begin
          if (r_iter_idx == LAST_ITER) begin
            w_next_state = ST_DONE;
          end else begin
            w_load      = 1'b1;
            w_load_val  = FIX_LOAD;
            w_next_iter = r_iter_idx + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (render_busy) begin
          w_next_state = ST_WAIT_RENDER;
        end else begin
          w_next_state = ST_IDLE;
          w_next_iter  = '0;
        end
      end
      ST_WAIT_RENDER: begin
        if (!render_busy) begin
          w_next_state = ST_IDLE;
          w_next_iter  = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_iter  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_verlet   <= 1'b0;
      r_fix      <= 1'b0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
      r_iter_idx <= '0;
      r_x_mouse  <= '0;
      r_y_mouse  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_verlet   <= (w_next_state == ST_VERLET);
      r_fix      <= (w_next_state == ST_FIX);
      r_finish   <= (w_next_state == ST_DONE);
      r_busy     <= (w_next_state != ST_IDLE);
      r_iter_idx <= w_next_iter;
      if ((r_state == ST_IDLE) && w_launch) begin
        r_x_mouse <= x_mouse_in;
        r_y_mouse <= y_mouse_in;
      end
    end
  end

  assign verlet_state         = r_verlet;
  assign fix_constraint_state = r_fix;
  assign finish_sig           = r_finish;
  assign busy                 = r_busy;
  assign iter_idx             = r_iter_idx;
  assign x_mouse              = r_x_mouse;
  assign y_mouse              = r_y_mouse;

endmodule
